mem_bus_arbiter: RTL and testbench

//  Shares one SRAM-like memory bus between the instruction-fetch port and the data
//  (load/store) port of the CPU. Data port carries byte strobes from store byte-enable

---
 rtl/mem_bus_arbiter_pkg.sv | 33 +++
 rtl/mem_bus_arbiter_if.sv | 24 ++
 rtl/mem_bus_arbiter_grant.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STREAK_W         = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ADDR  = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_LOCAL = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } arb_owner_t;

    function automatic logic [STREAK_W-1:0] streak_inc(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] limit
    );
        if (cur >= limit) begin
            return limit;
        end else begin
            return cur + 8'd1;
        end
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/response memory port: used for the fetch port, the data port and the shared bus.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  wr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter_grant.sv
// Grant decision for an idle arbiter: data first, fetch forced after a streak of data grants.
module mem_arb_grant
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_inst_req,
    input  logic i_data_req,
    output logic o_grant_inst,
    output logic o_grant_data
);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] r_streak;
    logic                w_force_inst;

    // Priority decision, only meaningful while the arbiter is idle
    always_comb begin
        w_force_inst = i_inst_req && (r_streak == LIMIT);
        o_grant_data = i_idle && i_data_req && !w_force_inst;
        o_grant_inst = i_idle && i_inst_req && !o_grant_data;
    end

    // Count data grants that overtook a waiting fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (o_grant_inst) begin
            r_streak <= '0;
        end else if (o_grant_data) begin
            r_streak <= i_inst_req ? streak_inc(r_streak, LIMIT) : '0;
        end else begin
            r_streak <= r_streak;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and load/store ports, one transaction in flight.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  inst_if,
    mem_bus_arbiter_if.slave  data_if,
    mem_bus_arbiter_if.master bus_if
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    arb_owner_t          r_owner;
    logic                r_wr;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic w_idle;
    logic w_grant_inst;
    logic w_grant_data;
    logic w_local_store;
    logic w_addr_ok;
    logic w_data_ok;
    logic w_local_done;

    assign w_idle        = (r_state == ARB_IDLE);
    assign w_local_store = w_grant_data && data_if.wr && (data_if.wstrb == '0);

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .i_idle       (w_idle),
        .i_inst_req   (inst_if.req),
        .i_data_req   (data_if.req),
        .o_grant_inst (w_grant_inst),
        .o_grant_data (w_grant_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a combined addr_ok+data_ok finishes straight from ADDR
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_local_store) begin
                    w_next_state = ARB_LOCAL;
                end else if (w_grant_inst || w_grant_data) begin
                    w_next_state = ARB_ADDR;
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (bus_if.addr_ok) begin
                    w_next_state = bus_if.data_ok ? ARB_IDLE : ARB_DATA;
                end else begin
                    w_next_state = ARB_ADDR;
                end
            end
            ARB_DATA:  w_next_state = bus_if.data_ok ? ARB_IDLE : ARB_DATA;
            ARB_LOCAL: w_next_state = ARB_IDLE;
            default:   w_next_state = ARB_IDLE;
        endcase
    end

    // Latch the granted request; fetches are always full-word reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_data) begin
            r_owner <= OWN_DATA;
            r_wr    <= data_if.wr;
            r_wstrb <= data_if.wr ? data_if.wstrb : '0;
            r_addr  <= data_if.addr;
            r_wdata <= data_if.wdata;
        end else if (w_grant_inst) begin
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_addr  <= inst_if.addr;
            r_wdata <= '0;
        end else begin
            r_owner <= r_owner;
            r_wr    <= r_wr;
            r_wstrb <= r_wstrb;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Bus drive and response steering to the owning port only
    always_comb begin
        w_addr_ok    = !rst && (r_state == ARB_ADDR) && bus_if.addr_ok;
        w_data_ok    = !rst && (((r_state == ARB_ADDR) && bus_if.addr_ok && bus_if.data_ok)
                               || ((r_state == ARB_DATA) && bus_if.data_ok));
        w_local_done = !rst && (r_state == ARB_LOCAL);

        bus_if.req = !rst && (r_state == ARB_ADDR);
        if (bus_if.req) begin
            bus_if.wr    = r_wr;
            bus_if.wstrb = r_wstrb;
            bus_if.addr  = r_addr;
            bus_if.wdata = r_wdata;
        end else begin
            bus_if.wr    = 1'b0;
            bus_if.wstrb = '0;
            bus_if.addr  = '0;
            bus_if.wdata = '0;
        end

        inst_if.addr_ok = w_addr_ok && (r_owner == OWN_INST);
        inst_if.data_ok = w_data_ok && (r_owner == OWN_INST);
        data_if.addr_ok = (w_addr_ok && (r_owner == OWN_DATA)) || w_local_done;
        data_if.data_ok = (w_data_ok && (r_owner == OWN_DATA)) || w_local_done;
        inst_if.rdata   = bus_if.rdata;
        data_if.rdata   = bus_if.rdata;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_if ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_if ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk     (clk),
        .rst     (rst),
        .inst_if (inst_if),
        .data_if (data_if),
        .bus_if  (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d got %0h exp %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: the transaction in flight (if any), whether the bus accepted it, and the streak
    bit         m_busy = 1'b0, m_acc = 1'b0, m_local = 1'b0, m_wr = 1'b0;
    int         m_owner = 0, m_streak = 0;
    logic [3:0] m_strb = 4'd0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;

    // Observed-event statistics for the hand-computed checks
    int c_breq = 0, c_ia = 0, c_id = 0, c_da = 0, c_dd = 0;
    int y_ia = -1, y_id = -1, y_da = -1, y_dd = -1;
    int glog[$];
    logic [4:0] blog[$];
    logic [31:0] alog[$];

    always @(negedge clk) begin : model
        bit e_ia, e_id, e_da, e_dd, e_req, take_data;
        bit n_busy, n_acc, n_local, n_wr;
        int n_owner, n_streak;
        logic [3:0] n_strb;
        logic [31:0] n_addr, n_wdata;
        e_ia = 0; e_id = 0; e_da = 0; e_dd = 0; e_req = 0; take_data = 0;
        n_busy = m_busy; n_acc = m_acc; n_local = m_local; n_wr = m_wr;
        n_owner = m_owner; n_streak = m_streak; n_strb = m_strb;
        n_addr = m_addr; n_wdata = m_wdata;
        if (rst) begin
            n_busy = 0; n_acc = 0; n_local = 0; n_owner = 0; n_streak = 0;
        end else if (!m_busy) begin
            take_data = data_if.req && !(inst_if.req && m_streak == LIM);
            if (take_data || inst_if.req) begin
                n_busy  = 1; n_acc = 0;
                n_owner = take_data ? 2 : 1;
                n_wr    = take_data && data_if.wr;
                n_strb  = n_wr ? data_if.wstrb : 4'd0;
                n_addr  = take_data ? data_if.addr : inst_if.addr;
                n_wdata = take_data ? data_if.wdata : 32'd0;
                n_local = n_wr && (data_if.wstrb == 4'd0);
                if (!take_data) n_streak = 0;
                else if (inst_if.req) n_streak = (m_streak < LIM) ? m_streak + 1 : LIM;
                else n_streak = 0;
            end
        end else if (m_local) begin
            e_da = 1; e_dd = 1; n_busy = 0;
        end else if (!m_acc) begin
            e_req = 1;
            if (bus_if.addr_ok) begin
                if (m_owner == 2) e_da = 1; else e_ia = 1;
                if (bus_if.data_ok) begin
                    if (m_owner == 2) e_dd = 1; else e_id = 1;
                    n_busy = 0;
                end else begin
                    n_acc = 1;
                end
            end
        end else if (bus_if.data_ok) begin
            if (m_owner == 2) e_dd = 1; else e_id = 1;
            n_busy = 0;
        end
        check("inst_addr_ok", inst_if.addr_ok, e_ia);
        check("inst_data_ok", inst_if.data_ok, e_id);
        check("data_addr_ok", data_if.addr_ok, e_da);
        check("data_data_ok", data_if.data_ok, e_dd);
        check("bus_req", bus_if.req, e_req);
        check("inst_rdata", inst_if.rdata, bus_if.rdata);
        check("data_rdata", data_if.rdata, bus_if.rdata);
        if (e_req) begin
            check("bus_wr", bus_if.wr, m_wr);
            check("bus_wstrb", bus_if.wstrb, m_strb);
            check("bus_addr", bus_if.addr, m_addr);
            check("bus_wdata", bus_if.wdata, m_wdata);
        end
        m_busy <= n_busy; m_acc <= n_acc; m_local <= n_local; m_wr <= n_wr;
        m_owner <= n_owner; m_streak <= n_streak; m_strb <= n_strb;
        m_addr <= n_addr; m_wdata <= n_wdata;
        if (bus_if.req) c_breq <= c_breq + 1;
        if (bus_if.req && bus_if.addr_ok) begin
            blog.push_back({bus_if.wr, bus_if.wstrb});
            alog.push_back(bus_if.addr);
        end
        if (inst_if.addr_ok) begin c_ia <= c_ia + 1; y_ia <= cyc; glog.push_back(1); end
        if (inst_if.data_ok) begin c_id <= c_id + 1; y_id <= cyc; end
        if (data_if.addr_ok) begin c_da <= c_da + 1; y_da <= cyc; glog.push_back(2); end
        if (data_if.data_ok) begin c_dd <= c_dd + 1; y_dd <= cyc; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.wstrb = 4'd0;
        inst_if.addr = 32'd0; inst_if.wdata = 32'd0;
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.wstrb = 4'd0;
        data_if.addr = 32'd0; data_if.wdata = 32'd0;
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
    endtask

    int s, b_breq, b_ia, b_id, b_da, b_dd, b_g, b_b;

    task automatic snap();
        s = cyc; b_breq = c_breq; b_ia = c_ia; b_id = c_id; b_da = c_da; b_dd = c_dd;
        b_g = glog.size(); b_b = blog.size();
    endtask

    initial begin
        clr_in();
        bus_if.rdata = 32'd0;
        rst = 1'b1;
        step(); step();
        check("rst_bus_req", bus_if.req, 1'b0);
        check("rst_inst_addr_ok", inst_if.addr_ok, 1'b0);
        check("rst_data_data_ok", data_if.data_ok, 1'b0);
        rst = 1'b0;
        step();

        // 1: lone fetch, bus accepts next cycle, data two cycles later
        snap();
        inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0000;
        step(); bus_if.addr_ok = 1'b1;
        step(); bus_if.addr_ok = 1'b0; inst_if.req = 1'b0;
        step(); bus_if.data_ok = 1'b1; bus_if.rdata = 32'h1234_5678;
        #1 check("t1_inst_rdata", inst_if.rdata, 32'h1234_5678);
        step(); bus_if.data_ok = 1'b0;
        step();
        check("t1_ia_cyc", y_ia, s + 1);
        check("t1_id_cyc", y_id, s + 3);
        check("t1_breq_cycles", c_breq - b_breq, 1);
        check("t1_id_pulses", c_id - b_id, 1);
        check("t1_data_silent", (c_da - b_da) + (c_dd - b_dd), 0);
        check("t1_bus_addr", alog[b_b], 32'hBFC0_0000);

        // 2: simultaneous requests, data store wins, fetch follows
        snap();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_1000;
        data_if.req = 1'b1; data_if.wr = 1'b1; data_if.wstrb = 4'b0100;
        data_if.addr = 32'h0000_0010; data_if.wdata = 32'h00AB_0000;
        step(); bus_if.addr_ok = 1'b1;
        step(); bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; data_if.req = 1'b0;
        step(); bus_if.data_ok = 1'b0;
        step(); bus_if.addr_ok = 1'b1; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h0BAD_F00D;
        step(); clr_in();
        step();
        check("t2_da_cyc", y_da, s + 1);
        check("t2_dd_cyc", y_dd, s + 2);
        check("t2_ia_cyc", y_ia, s + 4);
        check("t2_id_cyc", y_id, s + 4);
        check("t2_store_wr_strb", blog[b_b], 5'b1_0100);
        check("t2_fetch_wr_strb", blog[b_b + 1], 5'b0_0000);

        // 3: fetch held against back-to-back loads; fifth grant goes to fetch
        snap();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_0200;
        data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h0000_0100;
        bus_if.addr_ok = 1'b1; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h5555_AAAA;
        repeat (10) step();
        clr_in();
        step();
        check("t3_grant_count", glog.size() - b_g, 5);
        for (int i = 0; i < 4; i++) check("t3_data_grant", glog[b_g + i], 2);
        check("t3_fifth_is_inst", glog[b_g + 4], 1);
        check("t3_ia_cyc", y_ia, s + 9);

        // 4: zero-strobe store completes locally
        snap();
        data_if.req = 1'b1; data_if.wr = 1'b1; data_if.wstrb = 4'b0000;
        data_if.addr = 32'h0000_0020; data_if.wdata = 32'hDEAD_BEEF;
        step();
        step(); clr_in();
        step();
        check("t4_no_bus_req", c_breq - b_breq, 0);
        check("t4_da_cyc", y_da, s + 1);
        check("t4_dd_cyc", y_dd, s + 1);

        // 5: load with combined accept/response, then stray acks while idle
        snap();
        data_if.req = 1'b1; data_if.wr = 1'b0; data_if.wstrb = 4'hF; data_if.addr = 32'h0000_0040;
        step(); bus_if.addr_ok = 1'b1; bus_if.data_ok = 1'b1; bus_if.rdata = 32'hCAFE_F00D;
        #1 check("t5_data_rdata", data_if.rdata, 32'hCAFE_F00D);
        step(); data_if.req = 1'b0;
        step(); clr_in();
        step();
        check("t5_da_cyc", y_da, s + 1);
        check("t5_dd_cyc", y_dd, s + 1);
        check("t5_pulses", (c_da - b_da) + (c_dd - b_dd), 2);
        check("t5_load_strb", blog[b_b], 5'b0_0000);

        // 6: reset while waiting for data; the late response is discarded
        snap();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_0080;
        step(); bus_if.addr_ok = 1'b1;
        step(); bus_if.addr_ok = 1'b0; inst_if.req = 1'b0; rst = 1'b1;
        #1 check("t6_breq_in_rst", bus_if.req, 1'b0);
        step(); rst = 1'b0;
        step(); bus_if.data_ok = 1'b1;
        step(); bus_if.data_ok = 1'b0;
        step();
        check("t6_ia_pulses", c_ia - b_ia, 1);
        check("t6_no_id", c_id - b_id, 0);
        check("t6_breq_cycles", c_breq - b_breq, 1);

        // 7: load with two bus wait states before accept
        snap();
        data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h0000_0044;
        step();
        step();
        step(); bus_if.addr_ok = 1'b1;
        step(); bus_if.addr_ok = 1'b0; data_if.req = 1'b0;
        step(); bus_if.data_ok = 1'b1; bus_if.rdata = 32'h7777_0001;
        step(); clr_in();
        step();
        check("t7_breq_cycles", c_breq - b_breq, 3);
        check("t7_da_cyc", y_da, s + 3);
        check("t7_dd_cyc", y_dd, s + 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
